// File: rtl/mem_stage.sv
// Memory-access pipeline stage: takes ALU result, store data and control from
// EX, performs a valid/ready request/response transaction with data memory,
// formats load data, and presents registered writeback outputs.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    // Execute-stage interface
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_alu_do,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    output logic            mem_stall,
    // Data-memory request channel
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [3:0]      dmem_req_be,
    // Data-memory response channel
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    // Writeback interface
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic [XLEN-1:0] wb_data,
    output logic            mem_fault
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t          state_q;

    // Request fields, held stable while REQ waits for ready
    logic            req_valid_q;
    logic            req_we_q;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] req_wdata_q;
    logic [3:0]      req_be_q;

    // Instruction context kept for the response
    logic [4:0]      rd_q;
    logic            reg_write_q;
    logic [2:0]      funct3_q;
    logic [1:0]      lane_q;

    // Writeback registers
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic            wb_reg_write_q;
    logic [XLEN-1:0] wb_data_q;
    logic            mem_fault_q;

    // Combinational decode of the EX instruction
    logic            is_mem;
    logic            fault_d;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d;
    logic [XLEN-1:0] sb_wdata;
    logic [XLEN-1:0] sh_wdata;
    logic [XLEN-1:0] load_data_d;
    logic [7:0]      rsp_byte [4];
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign is_mem    = ex_mem_read | ex_mem_write;
    assign mem_stall = (state_q != IDLE);

    // Store byte and halfword data are replicated across all lanes so memory
    // can pick the lane selected by the byte enables.
    generate
        for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_sb_lane
            assign sb_wdata[8*gi +: 8] = ex_rs2_data[7:0];
        end
        for (genvar gi = 0; gi < XLEN / 16; gi++) begin : g_sh_lane
            assign sh_wdata[16*gi +: 16] = ex_rs2_data[15:0];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_rsp_lane
            assign rsp_byte[gi] = dmem_rsp_rdata[8*gi +: 8];
        end
    endgenerate

    // Fault detection: conflicting control, illegal width code, misalignment
    always_comb begin
        fault_d = 1'b0;
        if (ex_mem_read && ex_mem_write) begin
            fault_d = 1'b1;
        end else if (ex_mem_write) begin
            case (ex_funct3)
                3'b000:  fault_d = 1'b0;
                3'b001:  fault_d = ex_alu_do[0];
                3'b010:  fault_d = (ex_alu_do[1:0] != 2'b00);
                default: fault_d = 1'b1;
            endcase
        end else if (ex_mem_read) begin
            case (ex_funct3)
                3'b000, 3'b100: fault_d = 1'b0;
                3'b001, 3'b101: fault_d = ex_alu_do[0];
                3'b010:         fault_d = (ex_alu_do[1:0] != 2'b00);
                default:        fault_d = 1'b1;
            endcase
        end
    end

    // Store byte enables and write data; loads read the whole word
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = '0;
        if (ex_mem_write) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << ex_alu_do[1:0];
                    wdata_d = sb_wdata;
                end
                2'b01: begin
                    be_d    = ex_alu_do[1] ? 4'b1100 : 4'b0011;
                    wdata_d = sh_wdata;
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = ex_rs2_data;
                end
            endcase
        end
    end

    // Load formatting: lane select then sign or zero extension
    always_comb begin
        byte_sel    = rsp_byte[lane_q];
        half_sel    = lane_q[1] ? dmem_rsp_rdata[31:16] : dmem_rsp_rdata[15:0];
        load_data_d = dmem_rsp_rdata;
        case (funct3_q)
            3'b000:  load_data_d = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data_d = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b100:  load_data_d = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  load_data_d = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data_d = dmem_rsp_rdata;
        endcase
    end

    // Stage FSM with registered request and writeback outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            req_valid_q    <= 1'b0;
            req_we_q       <= 1'b0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_be_q       <= 4'b0000;
            rd_q           <= 5'd0;
            reg_write_q    <= 1'b0;
            funct3_q       <= 3'd0;
            lane_q         <= 2'd0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= '0;
            mem_fault_q    <= 1'b0;
        end else begin
            // Writeback strobes are single-cycle pulses
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            mem_fault_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem) begin
                            wb_valid_q     <= 1'b1;
                            wb_rd_q        <= ex_rd;
                            wb_reg_write_q <= ex_reg_write;
                            wb_data_q      <= ex_alu_do;
                        end else if (fault_d) begin
                            wb_valid_q     <= 1'b1;
                            wb_rd_q        <= ex_rd;
                            wb_data_q      <= ex_alu_do;
                            mem_fault_q    <= 1'b1;
                        end else begin
                            req_valid_q <= 1'b1;
                            req_we_q    <= ex_mem_write;
                            req_addr_q  <= {ex_alu_do[XLEN-1:2], 2'b00};
                            req_wdata_q <= wdata_d;
                            req_be_q    <= be_d;
                            rd_q        <= ex_rd;
                            reg_write_q <= ex_reg_write;
                            funct3_q    <= ex_funct3;
                            lane_q      <= ex_alu_do[1:0];
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (req_we_q) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= req_addr_q;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        wb_valid_q     <= 1'b1;
                        wb_rd_q        <= rd_q;
                        wb_reg_write_q <= reg_write_q;
                        wb_data_q      <= load_data_d;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req_valid = req_valid_q;
    assign dmem_req_we    = req_we_q;
    assign dmem_req_addr  = req_addr_q;
    assign dmem_req_wdata = req_wdata_q;
    assign dmem_req_be    = req_be_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_reg_write   = wb_reg_write_q;
    assign wb_data        = wb_data_q;
    assign mem_fault      = mem_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage, checked against a
// behavioural model of the load/store rules.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_do;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        mem_fault;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] load_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    mem_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .ex_alu_do      (ex_alu_do),
        .ex_rs2_data    (ex_rs2_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .mem_stall      (mem_stall),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_req_be    (dmem_req_be),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .wb_data        (wb_data),
        .mem_fault      (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_ex(input bit v, input bit rd_, input bit wr, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [31:0] rs2,
                            input logic [4:0] rd, input bit regw);
        ex_valid     = v;
        ex_mem_read  = rd_;
        ex_mem_write = wr;
        ex_funct3    = f3;
        ex_alu_do    = alu;
        ex_rs2_data  = rs2;
        ex_rd        = rd;
        ex_reg_write = regw;
    endtask

    // ---- reference model ----
    function automatic int unsigned access_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_fault(input bit rd_, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        if (rd_ && wr) return 1'b1;
        if (wr && f3 > 3'd2) return 1'b1;
        if (rd_ && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5))
            return 1'b1;
        return (a % access_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        int unsigned mask;
        sz   = access_size(f3);
        mask = ((1 << sz) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        if (access_size(f3) == 1) return (rs2 & 32'hFF) * 32'h01010101;
        if (access_size(f3) == 2) return (rs2 & 32'hFFFF) * 32'h00010001;
        return rs2;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] v;
        int unsigned off;
        off = a % 4;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * off)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // One complete transaction from accept to retirement.
    task automatic run_op(input string name, input bit rd_, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [4:0] rd, input bit regw, input logic [31:0] rdata,
                          input int ready_lat, input int rsp_lat, output logic [31:0] got);
        bit          is_mem;
        bit          flt;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        is_mem    = rd_ || wr;
        flt       = is_mem && model_fault(rd_, wr, f3, addr);
        exp_addr  = addr & 32'hFFFFFFFC;
        exp_be    = wr ? model_be(f3, addr) : 4'b1111;
        exp_wdata = wr ? model_wdata(f3, rs2) : 32'h0;
        got       = 32'h0;

        check({name, "_idle_stall"}, {31'd0, mem_stall}, 32'd0);
        drive_ex(1'b1, rd_, wr, f3, addr, rs2, rd, regw);
        step();
        drive_ex(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);

        if (!is_mem || flt) begin
            check({name, "_wbv"}, {31'd0, wb_valid}, 32'd1);
            check({name, "_fault"}, {31'd0, mem_fault}, {31'd0, flt});
            check({name, "_stall"}, {31'd0, mem_stall}, 32'd0);
            check({name, "_noreq"}, {31'd0, dmem_req_valid}, 32'd0);
            check({name, "_regw"}, {31'd0, wb_reg_write}, flt ? 32'd0 : {31'd0, regw});
            if (!flt) begin
                check({name, "_data"}, wb_data, addr);
                check({name, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
            end
            got = wb_data;
        end else begin
            for (int i = 0; i <= ready_lat; i++) begin
                check({name, "_stall_req"}, {31'd0, mem_stall}, 32'd1);
                check({name, "_reqv"}, {31'd0, dmem_req_valid}, 32'd1);
                check({name, "_we"}, {31'd0, dmem_req_we}, {31'd0, wr});
                check({name, "_addr"}, dmem_req_addr, exp_addr);
                check({name, "_be"}, {28'd0, dmem_req_be}, {28'd0, exp_be});
                check({name, "_wdata"}, dmem_req_wdata, exp_wdata);
                check({name, "_wbv_req"}, {31'd0, wb_valid}, 32'd0);
                if (i < ready_lat) step();
            end
            dmem_req_ready = 1'b1;
            step();
            dmem_req_ready = 1'b0;
            if (wr) begin
                check({name, "_wbv"}, {31'd0, wb_valid}, 32'd1);
                check({name, "_regw"}, {31'd0, wb_reg_write}, 32'd0);
                check({name, "_fault"}, {31'd0, mem_fault}, 32'd0);
                check({name, "_stall_end"}, {31'd0, mem_stall}, 32'd0);
            end else begin
                check({name, "_reqv_wait"}, {31'd0, dmem_req_valid}, 32'd0);
                check({name, "_stall_wait"}, {31'd0, mem_stall}, 32'd1);
                check({name, "_wbv_wait"}, {31'd0, wb_valid}, 32'd0);
                for (int i = 1; i < rsp_lat; i++) begin
                    dmem_rsp_rdata = $urandom;
                    step();
                    check({name, "_wbv_wait"}, {31'd0, wb_valid}, 32'd0);
                end
                dmem_rsp_valid = 1'b1;
                dmem_rsp_rdata = rdata;
                step();
                dmem_rsp_valid = 1'b0;
                check({name, "_wbv"}, {31'd0, wb_valid}, 32'd1);
                check({name, "_fault"}, {31'd0, mem_fault}, 32'd0);
                check({name, "_data"}, wb_data, model_load(f3, addr, rdata));
                check({name, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
                check({name, "_regw"}, {31'd0, wb_reg_write}, {31'd0, regw});
                check({name, "_stall_end"}, {31'd0, mem_stall}, 32'd0);
            end
            got = wb_data;
        end
        $display("[TB] %s rd=%0b wr=%0b f3=%0d addr=%h rs2=%h wb_data=%h fault=%0b",
                 name, rd_, wr, f3, addr, rs2, got, mem_fault);
    endtask

    initial begin
        logic [31:0] got;
        int          kind;
        bit          t_rd;
        bit          t_wr;
        logic [2:0]  t_f3;
        logic [31:0] t_addr;
        int unsigned sz;

        rst            = 1'b1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'h0;
        drive_ex(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);

        // Reset state
        step();
        step();
        check("rst_wbv", {31'd0, wb_valid}, 32'd0);
        check("rst_reqv", {31'd0, dmem_req_valid}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_fault", {31'd0, mem_fault}, 32'd0);
        check("rst_wbdata", wb_data, 32'h0);
        check("rst_addr", dmem_req_addr, 32'h0);
        check("rst_be", {28'd0, dmem_req_be}, 32'h0);
        rst = 1'b0;
        step();
        check("idle_no_wb", {31'd0, wb_valid}, 32'd0);

        // ALU pass-through
        run_op("alu", 1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 32'h0, 0, 1, got);
        check("alu_value", got, 32'h00001234);
        step();
        check("alu_pulse", {31'd0, wb_valid}, 32'd0);

        // SB with ready held low for 3 cycles
        run_op("sb", 1'b0, 1'b1, 3'd0, 32'h103, 32'h000000AB, 5'd0, 1'b0, 32'h0, 3, 1, got);

        // Byte and half loads, misaligned word
        run_op("lb", 1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 5'd3, 1'b1, 32'h00800000, 0, 1, got);
        check("lb_value", got, 32'hFFFFFF80);
        run_op("lbu", 1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 5'd3, 1'b1, 32'h00800000, 1, 2, got);
        check("lbu_value", got, 32'h00000080);
        run_op("lh", 1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 5'd4, 1'b1, 32'h80010000, 0, 1, got);
        check("lh_value", got, 32'hFFFF8001);
        run_op("lw_mis", 1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0, 0, 1, got);

        // Back-to-back LW, ALU, SW with response delay 2
        drive_ex(1'b1, 1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 5'd7, 1'b1);
        step();
        drive_ex(1'b1, 1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 5'd8, 1'b1);
        check("b2b_stall_req", {31'd0, mem_stall}, 32'd1);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        check("b2b_wbv_hs", {31'd0, wb_valid}, 32'd0);
        check("b2b_stall_hs", {31'd0, mem_stall}, 32'd1);
        step();
        check("b2b_wbv_delay", {31'd0, wb_valid}, 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hCAFEF00D;
        step();
        dmem_rsp_valid = 1'b0;
        check("b2b_lw_wbv", {31'd0, wb_valid}, 32'd1);
        check("b2b_lw_rd", {27'd0, wb_rd}, 32'd7);
        check("b2b_lw_data", wb_data, 32'hCAFEF00D);
        check("b2b_lw_stall", {31'd0, mem_stall}, 32'd0);
        step();
        check("b2b_alu_wbv", {31'd0, wb_valid}, 32'd1);
        check("b2b_alu_rd", {27'd0, wb_rd}, 32'd8);
        check("b2b_alu_data", wb_data, 32'h55);
        drive_ex(1'b1, 1'b0, 1'b1, 3'd2, 32'h204, 32'h13572468, 5'd0, 1'b0);
        step();
        drive_ex(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        check("b2b_sw_wbv", {31'd0, wb_valid}, 32'd0);
        check("b2b_sw_wdata", dmem_req_wdata, 32'h13572468);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        check("b2b_sw_wbv_end", {31'd0, wb_valid}, 32'd1);
        check("b2b_sw_regw", {31'd0, wb_reg_write}, 32'd0);
        $display("[TB] b2b LW/ALU/SW sequence done");

        // Reset while waiting for a response, then a stray response
        drive_ex(1'b1, 1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 5'd9, 1'b1);
        step();
        drive_ex(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        check("rw_stall", {31'd0, mem_stall}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rw_stall_rst", {31'd0, mem_stall}, 32'd0);
        check("rw_wbv_rst", {31'd0, wb_valid}, 32'd0);
        check("rw_reqv_rst", {31'd0, dmem_req_valid}, 32'd0);
        check("rw_wdata_rst", dmem_req_wdata, 32'h0);
        check("rw_fault_rst", {31'd0, mem_fault}, 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h12345678;
        step();
        dmem_rsp_valid = 1'b0;
        check("rw_stray_wbv", {31'd0, wb_valid}, 32'd0);
        step();
        check("rw_stray_wbv2", {31'd0, wb_valid}, 32'd0);
        $display("[TB] reset-in-wait sequence done");

        // Randomized transactions
        for (int t = 0; t < 80; t++) begin
            kind   = int'($urandom_range(0, 3));
            t_addr = $urandom;
            t_rd   = 1'b0;
            t_wr   = 1'b0;
            t_f3   = 3'($urandom_range(0, 7));
            if (kind == 1) begin
                t_rd = 1'b1;
                t_f3 = load_codes[$urandom_range(0, 4)];
            end else if (kind == 2) begin
                t_wr = 1'b1;
                t_f3 = 3'($urandom_range(0, 2));
            end else if (kind == 3) begin
                t_rd = ($urandom_range(0, 1) == 1);
                t_wr = !t_rd || ($urandom_range(0, 2) == 0);
            end
            if ((kind == 1 || kind == 2) && $urandom_range(0, 3) != 0) begin
                sz     = access_size(t_f3);
                t_addr = t_addr - (t_addr % sz);
            end
            run_op("rnd", t_rd, t_wr, t_f3, t_addr, $urandom, 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 1) == 1), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and writeback.
- Consumes the ALU result (address or value), store data and control from EX.
- Runs a valid/ready request/response handshake to data memory and formats load data with sign or zero extension.
- Stalls upstream while an access is outstanding and produces registered writeback outputs.

Parameters:
- XLEN, 32, datapath width; only 32 is supported for byte-enable generation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_funct3  in  3  RV32I load/store width/sign code
- ex_alu_do  in  XLEN  ALU result: effective address for memory ops, result otherwise
- ex_rs2_data  in  XLEN  store data
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- mem_stall  out  1  upstream must hold EX outputs stable
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1 = store
- dmem_req_addr  out  XLEN  word-aligned address, bits [1:0] = 0
- dmem_req_wdata  out  XLEN  lane-replicated store data
- dmem_req_be  out  4  byte enables
- dmem_rsp_valid  in  1  load data valid
- dmem_rsp_rdata  in  XLEN  raw 32-bit word
- wb_valid  out  1  one instruction retires to WB this cycle
- wb_rd  out  5  destination register
- wb_reg_write  out  1  register-file write enable
- wb_data  out  XLEN  writeback value
- mem_fault  out  1  misaligned or illegal access; qualified by wb_valid

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0: wb_*, dmem_req_*, mem_fault.
  - Any outstanding access is abandoned and a later stray dmem_rsp_valid is ignored.
- FSM states: IDLE, REQ, WAIT_RSP.
- mem_stall = (state != IDLE), taken combinationally from state only.
- Accept (IDLE, ex_valid=1):
  - Non-memory instruction: next cycle wb_valid=1, wb_data=ex_alu_do, wb_rd=ex_rd, wb_reg_write=ex_reg_write. Stay in IDLE, giving one instruction per cycle.
  - Fault: condition is
    - mem_read and mem_write both 1;
    - funct3 ∉ {000, 001, 010, 100, 101} for a load, or ∉ {000, 001, 010} for a store;
    - half access with addr[0]=1;
    - word access with addr[1:0]≠0.
  - On a fault: next cycle wb_valid=1, mem_fault=1, wb_reg_write=0; no dmem request is issued; stay in IDLE.
  - Legal memory op: latch the request fields and rd, go to REQ.
- REQ:
  - dmem_req_valid=1; all req fields are registered and held stable until dmem_req_ready=1.
  - On handshake, a store goes to IDLE with wb_valid=1, wb_reg_write=0 the next cycle.
  - On handshake, a load goes to WAIT_RSP.
- WAIT_RSP:
  - dmem_req_valid=0.
  - On dmem_rsp_valid, go to IDLE; next cycle wb_valid=1, wb_reg_write=latched reg_write, wb_data=formatted load.
  - A response in the same cycle as the request handshake is not allowed; memory latency is ≥1 cycle.
- Minimum latencies:
  - Store: 2 cycles from accept to wb_valid.
  - Load: 3 cycles from accept to wb_valid.
  - The upstream sees stall only from the cycle after accept. The EX instruction present in the accept cycle is consumed; the next instruction is held until state returns to IDLE.
- Store formatting (a = addr[1:0]):
  - SB: be = 4'b0001 << a; wdata = {4{rs2[7:0]}}.
  - SH: be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; wdata = rs2.
  - For loads, dmem_req_be=4'b1111 and wdata=0.
- Load formatting:
  - Select the byte at lane a or the half at lane a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- wb_valid is a single-cycle pulse per retired instruction; mem_fault is 0 whenever wb_valid is 0.
- ex_valid=0 in IDLE gives wb_valid=0 on the next cycle.

Test Plan:
- Reset, then ALU op ex_alu_do=0x1234, rd=5, reg_write=1 → next cycle wb_valid=1, wb_data=0x00001234, wb_rd=5, mem_stall never set.
- SB rs2=0x000000AB, addr=0x103 → dmem_req_addr=0x100, be=4'b1000, wdata=0xABABABAB; hold ready=0 for 3 cycles → fields stable and mem_stall=1; ready=1 → wb_valid=1 with wb_reg_write=0.
- LB addr=0x102, rsp_rdata=0x00800000 → wb_data=0xFFFFFF80; LBU at the same address → 0x00000080.
- LH addr=0x102, rsp_rdata=0x8001_0000 → 0xFFFF8001; LW addr=0x101 → mem_fault=1 with no dmem_req_valid.
- Back-to-back sequence LW, ALU, SW with rsp delay 2 → ALU instruction held by mem_stall, retires in order, one wb_valid each.
- rst asserted in WAIT_RSP → next cycle IDLE with all outputs 0; a late dmem_rsp_valid produces no wb_valid.
